// File: rtl/acl_filter.sv
// acl_filter: synchronises the packed X/Y/Z accelerometer bus and emits per-axis window means.
// Optional motion detector is built only when ACL_FILTER_MOTION_EN is defined.
module acl_filter #(
  parameter int         AVG_LOG2      = 3,
  parameter int         SAMPLE_DIV    = 100000,
  parameter int         STABLE_CYCLES = 4,
  parameter logic [4:0] MOTION_THRESH = 5'd4
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [14:0] acl_data,
  output logic [14:0] filt_data,
  output logic        filt_valid,
  output logic        motion
);

  localparam int AW = 5 + AVG_LOG2;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int NW = AVG_LOG2;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [14:0]          sync1_r;
  logic [14:0]          sync2_r;
  logic [14:0]          sync3_r;
  logic [SW-1:0]        stab_cnt_r;
  logic [TW-1:0]        tick_cnt_r;
  logic [NW-1:0]        samp_cnt_r;
  logic signed [AW-1:0] acc_r [3];
  logic signed [AW-1:0] sum_s [3];
  logic [14:0]          mean_s;
  logic                 tick_s;
  logic                 accept_s;
  logic                 close_s;
  logic                 motion_hit_s;

  assign tick_s   = (tick_cnt_r == TW'(SAMPLE_DIV - 1));
  assign accept_s = tick_s && (stab_cnt_r == SW'(STABLE_CYCLES));
  assign close_s  = accept_s && (samp_cnt_r == {NW{1'b1}});

  // sync3 is the previous sync2; the bus is only trusted after it has held still for a while
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync1_r    <= 15'd0;
      sync2_r    <= 15'd0;
      sync3_r    <= 15'd0;
      stab_cnt_r <= {SW{1'b0}};
    end else begin
      sync1_r <= acl_data;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      if (sync2_r != sync3_r) begin
        stab_cnt_r <= {SW{1'b0}};
      end else if (stab_cnt_r != SW'(STABLE_CYCLES)) begin
        stab_cnt_r <= stab_cnt_r + SW'(1);
      end else begin
        stab_cnt_r <= stab_cnt_r;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Arithmetic shift floors toward -inf; only the low 5 bits of each mean are kept
  always_comb begin
    mean_s = 15'd0;
    for (int a = 0; a < 3; a++) begin
      sum_s[a] = acc_r[a] + signed'({{AVG_LOG2{sync2_r[a*5+4]}}, sync2_r[a*5 +: 5]});
      mean_s[a*5 +: 5] = 5'(sum_s[a] >>> AVG_LOG2);
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      samp_cnt_r <= {NW{1'b0}};
      for (int a = 0; a < 3; a++) begin
        acc_r[a] <= {AW{1'b0}};
      end
    end else if (accept_s) begin
      if (close_s) begin
        samp_cnt_r <= {NW{1'b0}};
        for (int a = 0; a < 3; a++) begin
          acc_r[a] <= {AW{1'b0}};
        end
      end else begin
        samp_cnt_r <= samp_cnt_r + NW'(1);
        for (int a = 0; a < 3; a++) begin
          acc_r[a] <= sum_s[a];
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_r <= S_FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FILL: begin
        if (close_s) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_FILL;
        end
      end
      S_RUN:   state_nxt_s = S_RUN;
      default: state_nxt_s = S_FILL;
    endcase
  end

`ifdef ACL_FILTER_MOTION_EN
  logic [14:0] prev_data_r;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      prev_data_r <= 15'd0;
    end else if (close_s) begin
      prev_data_r <= mean_s;
    end
  end

  // Per-axis |new - prev| in 6-bit signed arithmetic; magnitude never exceeds 31
  always_comb begin
    logic [5:0] diff_s;
    logic [5:0] mag_s;
    motion_hit_s = 1'b0;
    diff_s       = 6'd0;
    mag_s        = 6'd0;
    for (int a = 0; a < 3; a++) begin
      diff_s = {mean_s[a*5+4], mean_s[a*5 +: 5]} - {prev_data_r[a*5+4], prev_data_r[a*5 +: 5]};
      mag_s  = diff_s[5] ? (6'd0 - diff_s) : diff_s;
      if (mag_s >= {1'b0, MOTION_THRESH}) begin
        motion_hit_s = 1'b1;
      end else begin
        motion_hit_s = motion_hit_s;
      end
    end
  end
`else
  assign motion_hit_s = 1'b0;
`endif

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      filt_data  <= 15'd0;
      filt_valid <= 1'b0;
      motion     <= 1'b0;
    end else begin
      filt_valid <= close_s;
      motion     <= close_s && (state_r == S_RUN) && motion_hit_s;
      if (close_s) begin
        filt_data <= mean_s;
      end
    end
  end

endmodule

// File: tb/tb_acl_filter.sv
// Directed self-checking bench for acl_filter (SAMPLE_DIV=10, STABLE_CYCLES=4, AVG_LOG2=3).
// Motion expectations follow ACL_FILTER_MOTION_EN.
module tb_acl_filter;

  logic        CLK100MHZ = 1'b0;
  logic        reset;
  logic [14:0] acl_data;
  logic [14:0] filt_data;
  logic        filt_valid;
  logic        motion;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int vcount   = 0;
  int consec   = 0;
  logic prev_v = 1'b0;

`ifdef ACL_FILTER_MOTION_EN
  localparam logic MOT_ON = 1'b1;
`else
  localparam logic MOT_ON = 1'b0;
`endif

  always #5 CLK100MHZ = ~CLK100MHZ;

  acl_filter #(
    .AVG_LOG2(3), .SAMPLE_DIV(10), .STABLE_CYCLES(4), .MOTION_THRESH(5'd4)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .acl_data(acl_data),
    .filt_data(filt_data), .filt_valid(filt_valid), .motion(motion)
  );

  // Cycle count since reset release; a tick fires on every edge where it reaches a multiple of 10
  always @(posedge CLK100MHZ or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge CLK100MHZ) begin
    if (filt_valid) vcount <= vcount + 1;
    if (filt_valid && prev_v) consec <= consec + 1;
    prev_v <= filt_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  function automatic logic [14:0] pk(input int x, input int y, input int z);
    return {x[4:0], y[4:0], z[4:0]};
  endfunction

  // Present one sample and return right after the tick edge that accepts it
  task automatic feed(input logic [14:0] d);
    acl_data = d;
    @(negedge CLK100MHZ);
    while (cyc % 10 != 0) @(negedge CLK100MHZ);
  endtask

  task automatic do_reset();
    @(negedge CLK100MHZ);
    reset = 1'b1;
    repeat (2) @(negedge CLK100MHZ);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int v0;
    acl_data = pk(3, 2, -1);
    reset = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    checks++;
    if (filt_data !== 15'd0 || filt_valid !== 1'b0 || motion !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs data=%h valid=%b motion=%b expected 0 0 0", filt_data, filt_valid, motion);
    end
    reset = 1'b0;
    v0 = vcount;
    for (int i = 0; i < 8; i++) begin
      feed(pk(3, 2, -1));
      if (i == 6) begin
        checks++;
        if (vcount !== v0) begin
          failures++;
          $display("FAIL fill_early_valid pulses=%0d expected %0d", vcount - v0, 0);
        end
      end
    end
    checks++;
    if (filt_valid !== 1'b1 || filt_data !== pk(3, 2, -1)) begin
      failures++;
      $display("FAIL fill_first_window valid=%b data=%b expected 1 %b", filt_valid, filt_data, pk(3, 2, -1));
    end
    checks++;
    if (motion !== 1'b0) begin
      failures++;
      $display("FAIL fill_motion got=%b expected 0", motion);
    end
    @(negedge CLK100MHZ);
    checks++;
    if (filt_valid !== 1'b0 || filt_data !== pk(3, 2, -1)) begin
      failures++;
      $display("FAIL valid_width valid=%b data=%b expected 0 %b", filt_valid, filt_data, pk(3, 2, -1));
    end
  endtask

  task automatic test_rounding();
    do_reset();
    for (int i = 0; i < 8; i++) feed(pk((i % 2) ? 5 : 4, 0, (i % 2) ? -2 : -1));
    checks++;
    if (filt_valid !== 1'b1 || filt_data !== pk(4, 0, -2)) begin
      failures++;
      $display("FAIL round_floor valid=%b data=%b expected 1 %b", filt_valid, filt_data, pk(4, 0, -2));
    end
    for (int i = 0; i < 8; i++) feed(pk(-16, 15, (i == 0) ? -1 : 0));
    checks++;
    if (filt_valid !== 1'b1 || filt_data !== pk(-16, 15, -1)) begin
      failures++;
      $display("FAIL round_extremes valid=%b data=%b expected 1 %b", filt_valid, filt_data, pk(-16, 15, -1));
    end
    checks++;
    if (motion !== MOT_ON) begin
      failures++;
      $display("FAIL round_motion got=%b expected %b", motion, MOT_ON);
    end
  endtask

  task automatic test_instability();
    int v0;
    do_reset();
    v0 = vcount;
    for (int i = 0; i < 100; i++) begin
      acl_data = (i % 2) ? 15'h7fff : 15'h0000;
      repeat (2) @(negedge CLK100MHZ);
    end
    checks++;
    if (vcount !== v0 || filt_data !== 15'd0) begin
      failures++;
      $display("FAIL unstable_no_accept pulses=%0d data=%h expected 0 0", vcount - v0, filt_data);
    end
    for (int i = 0; i < 8; i++) feed(pk(7, -3, 1));
    checks++;
    if (filt_valid !== 1'b1 || filt_data !== pk(7, -3, 1)) begin
      failures++;
      $display("FAIL unstable_resume valid=%b data=%b expected 1 %b", filt_valid, filt_data, pk(7, -3, 1));
    end
  endtask

  task automatic test_reset_mid_window();
    int v0;
    do_reset();
    for (int i = 0; i < 8; i++) feed(pk(1, 1, 1));
    checks++;
    if (filt_valid !== 1'b1 || filt_data !== pk(1, 1, 1)) begin
      failures++;
      $display("FAIL mid_pre_window valid=%b data=%b expected 1 %b", filt_valid, filt_data, pk(1, 1, 1));
    end
    for (int i = 0; i < 5; i++) feed(pk(15, 15, 15));
    reset = 1'b1;
    #1;
    checks++;
    if (filt_data !== 15'd0 || filt_valid !== 1'b0 || motion !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_clear data=%h valid=%b motion=%b expected 0 0 0", filt_data, filt_valid, motion);
    end
    repeat (2) @(negedge CLK100MHZ);
    reset = 1'b0;
    v0 = vcount;
    for (int i = 0; i < 8; i++) begin
      feed(pk(-8, 3, 0));
      if (i == 6) begin
        checks++;
        if (vcount !== v0) begin
          failures++;
          $display("FAIL mid_early_valid pulses=%0d expected %0d", vcount - v0, 0);
        end
      end
    end
    checks++;
    if (filt_valid !== 1'b1 || filt_data !== pk(-8, 3, 0) || motion !== 1'b0) begin
      failures++;
      $display("FAIL mid_fresh_window valid=%b data=%b motion=%b expected 1 %b 0",
               filt_valid, filt_data, motion, pk(-8, 3, 0));
    end
  endtask

  task automatic test_motion();
    do_reset();
    for (int i = 0; i < 8; i++) feed(pk(0, 0, 0));
    checks++;
    if (filt_valid !== 1'b1 || motion !== 1'b0) begin
      failures++;
      $display("FAIL motion_w1 valid=%b motion=%b expected 1 0", filt_valid, motion);
    end
    for (int i = 0; i < 8; i++) feed(pk(6, 0, 0));
    checks++;
    if (filt_valid !== 1'b1 || filt_data !== pk(6, 0, 0) || motion !== MOT_ON) begin
      failures++;
      $display("FAIL motion_w2 valid=%b data=%b motion=%b expected 1 %b %b",
               filt_valid, filt_data, motion, pk(6, 0, 0), MOT_ON);
    end
    @(negedge CLK100MHZ);
    checks++;
    if (motion !== 1'b0 || filt_valid !== 1'b0) begin
      failures++;
      $display("FAIL motion_width motion=%b valid=%b expected 0 0", motion, filt_valid);
    end
    for (int i = 0; i < 8; i++) feed(pk(3, 0, 0));
    checks++;
    if (filt_valid !== 1'b1 || filt_data !== pk(3, 0, 0) || motion !== 1'b0) begin
      failures++;
      $display("FAIL motion_w3 valid=%b data=%b motion=%b expected 1 %b 0",
               filt_valid, filt_data, motion, pk(3, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK100MHZ);
    checks++;
    if (consec !== 0) begin
      failures++;
      $display("FAIL valid_consecutive count=%0d expected 0", consec);
    end
    checks++;
    if (vcount !== 9) begin
      failures++;
      $display("FAIL valid_total got=%0d expected 9", vcount);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_instability();
    test_reset_mid_window();
    test_motion();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acl_filter.md
# acl_filter

Per-axis windowed averaging stage between the SPI accelerometer master and its consumers, the 7-segment display controller and the LEDs. It takes the packed 15-bit X/Y/Z sample bus produced in the 4 MHz SPI domain and re-times it into the CLK100MHZ domain with a stability qualifier. It samples the bus at a fixed rate and emits the mean of every 2^AVG_LOG2 accepted samples, with a one-cycle valid strobe, removing LED and display flicker.

## Interface
- AVG_LOG2, default 3: log2 of the window length (8 samples); legal range 1..6.
- SAMPLE_DIV, default 100000: CLK100MHZ cycles per sample tick (1 kHz).
- STABLE_CYCLES, default 4: consecutive identical synchronized cycles required before a tick may accept.
- MOTION_THRESH, default 4: per-axis delta threshold for `motion` (unsigned, 5 bits).
- CLK100MHZ  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- acl_data  in  15  raw sample: X=[14:10], Y=[9:5], Z=[4:0], each 5-bit two's complement; asynchronous to CLK100MHZ.
- filt_data  out  15  averaged sample, same packing; reset 0.
- filt_valid  out  1  one-cycle pulse when filt_data updates; reset 0.
- motion  out  1  one-cycle pulse coincident with filt_valid; reset 0.

## Operation
- Sync: acl_data passes through two flops (sync1, sync2), all 15 bits.
- Stability: stab_cnt clears to 0 when sync2 != previous sync2, otherwise increments and saturates at STABLE_CYCLES.
- Tick: tick_cnt counts 0..SAMPLE_DIV-1 and wraps; tick = (tick_cnt == SAMPLE_DIV-1). It free-runs regardless of stability.
- Accept: accept = tick && stab_cnt == STABLE_CYCLES. A tick that finds the bus unstable is skipped; there is no retry before the next tick.
- Accumulate: three signed accumulators, width 5+AVG_LOG2, each adding the sign-extended field on accept. samp_cnt counts accepts, 0..2^AVG_LOG2-1.
- Window close: on the accept where samp_cnt == 2^AVG_LOG2-1:
  - next cycle, filt_data[axis] = (acc+sample) >>> AVG_LOG2, an arithmetic shift that floors toward -inf; take the low 5 bits.
  - filt_valid pulses; accumulators and samp_cnt clear to 0.
- FSM:
  - S_FILL (reset state): filt_valid and motion are suppressed until the first window closes. The first window close drives filt_data and filt_valid normally, then the FSM goes to S_RUN.
  - S_RUN: every window close updates the outputs. The FSM leaves S_RUN only through reset.
- Motion: see Configuration. prev_data holds the previous filt_data and is loaded at every window close.
- Reset at any time clears sync flops, counters, accumulators, prev_data and outputs, and the FSM returns to S_FILL. A partially filled window is discarded.

## Timing
- Input to sync2: 2 cycles. Stability adds STABLE_CYCLES cycles.
- Accept to filt_data/filt_valid: 1 cycle after the window-closing accept.
- First filt_valid after reset release: no earlier than 2^AVG_LOG2 × SAMPLE_DIV cycles.
- filt_valid is high for exactly 1 cycle and never on consecutive cycles (SAMPLE_DIV ≥ 2 required).
- filt_data holds its value between pulses; consumers may sample it at any time.
- Between pulses, an input change only affects filt_data through accepted samples.

## Configuration
- ACL_FILTER_MOTION_EN defined:
  - at each window close in S_RUN, motion = 1 for that cycle if any axis satisfies |new − prev_data| ≥ MOTION_THRESH, using signed 6-bit subtraction and absolute value.
  - The first window after reset never asserts motion.
- ACL_FILTER_MOTION_EN undefined: motion is tied to 0, no prev_data or comparator logic exists, and MOTION_THRESH is ignored. The port is present in both builds.

## Test plan
All scenarios use SAMPLE_DIV=10, STABLE_CYCLES=4, AVG_LOG2=3.
- Reset/fill:
  - Stimulus: hold reset with acl_data = 00011_00010_11111 (X=3, Y=2, Z=−1), then release.
  - Response: all outputs 0 during reset. The first filt_valid arrives after the 8th accept with filt_data = 00011_00010_11111; motion = 0.
- Rounding:
  - Stimulus: alternate X = 4 and 5 per tick; separately, alternate Z = −1 and −2 per tick.
  - Response: filt X = 4 (00100); filt Z = −2 (11110).
- Instability: toggling acl_data every 2 cycles produces no accepts and no filt_valid for 200 cycles. Holding the input steady afterwards resumes normal windows.
- Reset mid-window: asserting reset after 5 accepts clears all outputs. The next filt_valid requires 8 fresh accepts, and the old samples do not contribute.
- Motion, with ACL_FILTER_MOTION_EN defined:
  - window 1 X=0, window 2 X=6 → motion pulses with the second filt_valid;
  - window 3 X=3 → no pulse.
  - With the macro undefined, motion stays 0 throughout.
